// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable UART transmitter (5-9 data bits, none/odd/even parity, 1-2 stop bits) with valid/ready input
// Ports: sys_clk, sys_rst_n (async, active-low); in_data/in_valid/in_ready character handshake;
//        tx serial line (idles high); busy frame in progress; tx_done pulse in final stop-bit cycle.
// Define UART_TX_FIFO_EN to place a FIFO_DEPTH-entry FIFO ahead of the serialiser.
module uart_tx_cfg #(
  parameter int CLK_FREQ   = 25_000_000,
  parameter int UART_BPS   = 921600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);
  localparam int BPS_CNT = CLK_FREQ / UART_BPS;
  localparam int CW = $clog2(BPS_CNT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(BPS_CNT - 1);
  localparam logic [CW-1:0] CNT_PRE = CW'(BPS_CNT - 2);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  if (BPS_CNT < 4 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      (STOP_BITS != 1 && STOP_BITS != 2) || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
    $error("uart_tx_cfg: illegal parameter combination");
  end
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic par_bit;
  logic take;
  logic [DATA_BITS-1:0] src;
  logic baud_end;
  assign baud_end = cnt == CNT_LAST;
`ifdef UART_TX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic full, empty, wr;
  assign full = count == (AW+1)'(FIFO_DEPTH);
  assign empty = count == '0;
  assign in_ready = !full;
  assign wr = in_valid && in_ready;
  assign take = state == IDLE && !empty;
  assign src = mem[rd_ptr];
  assign busy = state != IDLE || !empty;
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= take ? rd_ptr + 1'b1 : rd_ptr;
      count <= count + (AW+1)'(wr) - (AW+1)'(take);
    end
  always_ff @(posedge sys_clk)
    if (wr) mem[wr_ptr] <= in_data;
`else
  assign in_ready = state == IDLE;
  assign take = in_valid && in_ready;
  assign src = in_data;
  assign busy = state != IDLE;
`endif
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      shreg <= '0;
      par_bit <= 1'b0;
      tx <= 1'b1;
      tx_done <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      cnt <= (state == IDLE || baud_end) ? '0 : cnt + 1'b1;
      case (state)
        IDLE: if (take) begin
          state <= START;
          tx <= 1'b0;
          shreg <= src;
          par_bit <= ^src ^ (PARITY == 1);
          bit_idx <= '0;
        end
        START: if (baud_end) begin
          state <= DATA;
          tx <= shreg[0];
        end
        DATA: if (baud_end) begin
          if (bit_idx == BIT_LAST) begin
            state <= PARITY != 0 ? PAR : STOP;
            tx <= PARITY != 0 ? par_bit : 1'b1;
            bit_idx <= '0;
          end else begin
            bit_idx <= bit_idx + 1'b1;
            shreg <= shreg >> 1;
            tx <= shreg[1];
          end
        end
        PAR: if (baud_end) begin
          state <= STOP;
          tx <= 1'b1;
        end
        STOP: begin
          // registered pulse: raise one cycle early so it is high in the final stop cycle
          if (cnt == CNT_PRE && bit_idx == STOP_LAST) tx_done <= 1'b1;
          if (baud_end) begin
            state <= bit_idx == STOP_LAST ? IDLE : STOP;
            bit_idx <= bit_idx == STOP_LAST ? '0 : bit_idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule
